counter_arb: RTL

COUNTER_ARB -- requirements
Module: counter_arb

---
 rtl/counter_arb_pkg.sv | 12 +
 rtl/counter_arb_core.sv | 44 ++++
 rtl/counter_arb.sv | 96 +++++++++
 3 files changed

// File: rtl/counter_arb_pkg.sv
// Shared FSM state encoding and default sizing for the counter_arb slice.
package counter_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam int DEFAULT_NREQ  = 4;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_arb_core.sv
// counter_core: shared count register with synchronous clear and single-step increment.
// Defining COUNTER_ARB_SAT_EN makes the count saturate at its maximum instead of wrapping.
module counter_core
  import counter_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear has priority; the arbiter never enables in a cycle it also clears.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
`ifdef COUNTER_ARB_SAT_EN
      if (count_q != '1) begin
        count_d = count_q + WIDTH'(1);
      end
`else
      count_d = count_q + WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter that grants one shared-counter increment per request.
// Optional build macro COUNTER_ARB_SAT_EN (saturating counter) is handled in counter_core.
module counter_arb
  import counter_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] value,
  output logic             overflow,
  output logic             busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDXW-1:0] idx_t;

  state_e          state_q;
  idx_t            last_q;
  idx_t            sel_q;
  logic [NREQ-1:0] ack_q;
  logic            overflow_q;

  idx_t            selIdx;
  idx_t            candIdx;
  logic            found;
  logic            grant;
  logic [WIDTH-1:0] count;

  // Round-robin search starting one past the last winner; first set bit wins.
  always_comb begin
    selIdx  = last_q;
    candIdx = last_q;
    found   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      candIdx = idx_t'((int'(last_q) + i) % NREQ);
      if (!found && req[candIdx]) begin
        selIdx = candIdx;
        found  = 1'b1;
      end
    end
  end

  assign grant = (state_q == IDLE) && !clear && found;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (grant),
    .count  (count)
  );

  // Overflow is judged on the pre-increment count sampled at the grant edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= idx_t'(NREQ - 1);
      sel_q      <= '0;
      ack_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q    <= ACK;
            sel_q      <= selIdx;
            ack_q      <= NREQ'(1) << selIdx;
            overflow_q <= (count == '1);
          end
        end
        ACK: begin
          state_q    <= IDLE;
          last_q     <= sel_q;
          ack_q      <= '0;
          overflow_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          ack_q      <= '0;
          overflow_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == ACK);
  assign value    = count;

endmodule
